// File: rtl/n1_pbus_pkg.sv
// Shared definitions for the N1 program bus (initiator and responder side).
// Response kinds, responder FSM states and bus width constants.
package n1_pbus_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADR_W  = 16;

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_ACK,
        RESP_ERR,
        RESP_RTY
    } resp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/n1_pbus_mem_ram.sv
// Word memory for n1_pbus_mem: one write port shared by bus and backdoor,
// one synchronous read port.
// Ports: clk_i; bus_we/bus_adr/bus_dat (bus write + read address);
//        init_we/init_adr/init_dat (backdoor write); rd_en; rd_dat (registered).
module n1_pbus_mem_ram
    import n1_pbus_pkg::*;
#(
    parameter int unsigned ADR_WIDTH = 10
) (
    input  logic                 clk_i,
    input  logic                 bus_we,
    input  logic [ADR_WIDTH-1:0] bus_adr,
    input  logic [WORD_W-1:0]    bus_dat,
    input  logic                 init_we,
    input  logic [ADR_WIDTH-1:0] init_adr,
    input  logic [WORD_W-1:0]    init_dat,
    input  logic                 rd_en,
    output logic [WORD_W-1:0]    rd_dat
);

    localparam int unsigned DEPTH = 1 << ADR_WIDTH;

    logic [WORD_W-1:0]    mem [DEPTH];
    logic                 wr_en;
    logic [ADR_WIDTH-1:0] wr_adr;
    logic [WORD_W-1:0]    wr_dat;

    // Backdoor owns the port whenever it writes.
    assign wr_en  = init_we | bus_we;
    assign wr_adr = init_we ? init_adr : bus_adr;
    assign wr_dat = init_we ? init_dat : bus_dat;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_adr] <= wr_dat;
        end
        // Holds its value until the next read so slow responses keep data.
        if (rd_en) begin
            rd_dat <= mem[bus_adr];
        end
    end

endmodule

// File: rtl/n1_pbus_mem.sv
// Pipelined program-bus responder: word memory with wait states, ERR on
// out-of-range address, RTY on backdoor collision.
// Ports: clk_i, sync_rst_i (active-low sync); pbus_* request/response;
//        init_* backdoor write; prb_mem_busy_o probe (request pending).
module n1_pbus_mem
    import n1_pbus_pkg::*;
#(
    parameter int unsigned ADR_WIDTH   = 10,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [15:0] ADR_OFFSET  = 16'h0000
) (
    input  logic                 clk_i,
    input  logic                 sync_rst_i,
    input  logic                 pbus_cyc_i,
    input  logic                 pbus_stb_i,
    input  logic                 pbus_we_i,
    input  logic [ADR_W-1:0]     pbus_adr_i,
    input  logic [WORD_W-1:0]    pbus_dat_i,
    output logic                 pbus_ack_o,
    output logic                 pbus_err_o,
    output logic                 pbus_rty_o,
    output logic                 pbus_stall_o,
    output logic [WORD_W-1:0]    pbus_dat_o,
    input  logic                 init_we_i,
    input  logic [ADR_WIDTH-1:0] init_adr_i,
    input  logic [WORD_W-1:0]    init_dat_i,
    output logic                 prb_mem_busy_o
);

    localparam logic [3:0] WS      = 4'(WAIT_STATES);
    localparam bit         NO_WAIT = (WAIT_STATES == 0);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    resp_t             pend_q, pend_d;
    logic              rd_q, rd_d;
    resp_t             resp_d;
    logic              ack_q, err_q, rty_q;
    logic              stall_q, busy_q;
    logic [ADR_W-1:0]  idx_full;
    logic              in_range;
    logic              accept;
    resp_t             cls;
    logic              bus_we;
    logic              rd_en;
    logic [WORD_W-1:0] ram_q;

    // Subtraction wraps modulo 2^16, so offsets near the top of the
    // address space map low bus addresses onto the upper words.
    assign idx_full = pbus_adr_i - ADR_OFFSET;
    assign in_range = (idx_full >> ADR_WIDTH) == '0;
    assign accept   = pbus_cyc_i & pbus_stb_i & ~stall_q;

    always_comb begin
        if (!in_range) begin
            cls = RESP_ERR;
        end else if (init_we_i) begin
            cls = RESP_RTY;
        end else begin
            cls = RESP_ACK;
        end
    end

    assign bus_we = sync_rst_i & accept & pbus_we_i & (cls == RESP_ACK);
    assign rd_en  = sync_rst_i & accept & ~pbus_we_i & (cls == RESP_ACK);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        rd_d    = rd_q;
        resp_d  = RESP_NONE;
        case (state_q)
            // With no wait states RESP is also an accepting state.
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (accept) begin
                    pend_d = cls;
                    rd_d   = ~pbus_we_i;
                    if (NO_WAIT) begin
                        state_d = ST_RESP;
                        resp_d  = cls;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS;
                    end
                end
            end
            ST_WAIT: begin
                if (!pbus_cyc_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                    resp_d  = pend_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!sync_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= RESP_NONE;
            rd_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            stall_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            rd_q    <= rd_d;
            ack_q   <= (resp_d == RESP_ACK);
            err_q   <= (resp_d == RESP_ERR);
            rty_q   <= (resp_d == RESP_RTY);
            stall_q <= !NO_WAIT && (state_d != ST_IDLE);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    n1_pbus_mem_ram #(
        .ADR_WIDTH(ADR_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .bus_we  (bus_we),
        .bus_adr (idx_full[ADR_WIDTH-1:0]),
        .bus_dat (pbus_dat_i),
        .init_we (init_we_i),
        .init_adr(init_adr_i),
        .init_dat(init_dat_i),
        .rd_en   (rd_en),
        .rd_dat  (ram_q)
    );

    assign pbus_ack_o     = ack_q;
    assign pbus_err_o     = err_q;
    assign pbus_rty_o     = rty_q;
    assign pbus_stall_o   = stall_q;
    assign prb_mem_busy_o = busy_q;
    assign pbus_dat_o     = (ack_q && rd_q) ? ram_q : '0;

endmodule
